// File: rtl/range_stats_if.sv
// Sample stream in, windowed min/max/range results out.
interface range_stats_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) ();
    logic [WIDTH-1:0]     data_in;
    logic                 data_valid;
    logic                 go;
    logic                 finish;
    logic [WIDTH-1:0]     min_val;
    logic [WIDTH-1:0]     max_val;
    logic [WIDTH-1:0]     range;
    logic [CNT_WIDTH-1:0] count;
    logic                 count_sat;
    logic                 done;
    logic                 busy;
    logic                 error;

    modport master (
        output data_in, data_valid, go, finish,
        input  min_val, max_val, range, count, count_sat, done, busy, error
    );

    modport slave (
        input  data_in, data_valid, go, finish,
        output min_val, max_val, range, count, count_sat, done, busy, error
    );
endinterface

// File: rtl/range_stats_tracker.sv
// Streaming min/max/range tracker over a go..finish window with
// registered results, done strobe and a sticky protocol-error state.
module range_stats_tracker #(
    parameter int WIDTH     = 16,
    parameter int SIGNED    = 0,
    parameter int CNT_WIDTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    range_stats_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_ERROR  = 2'd2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]           state;
    logic [WIDTH-1:0]     cur_min, cur_max;
    logic [CNT_WIDTH-1:0] cur_cnt;
    logic                 cur_sat, cur_empty;

    logic [WIDTH-1:0]     nxt_min, nxt_max;
    logic [CNT_WIDTH-1:0] nxt_cnt;
    logic                 nxt_sat, nxt_empty;
    logic [WIDTH-1:0]     res_min, res_max;

    logic [WIDTH-1:0]     min_q, max_q, range_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 sat_q, done_q;

    logic active, start, proto_err;

    function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) < $signed(b);
        else             return a < b;
    endfunction

    assign active    = (state == S_ACTIVE);
    assign proto_err = (bus.go && bus.finish) || (bus.finish && !active) || (bus.go && active);
    assign start     = bus.go && !bus.finish && !active;

    // Tracker update for a sample arriving while the window is open.
    always_comb begin
        nxt_min   = cur_min;
        nxt_max   = cur_max;
        nxt_cnt   = cur_cnt;
        nxt_sat   = cur_sat;
        nxt_empty = cur_empty;
        if (bus.data_valid) begin
            if (cur_empty) begin
                nxt_min   = bus.data_in;
                nxt_max   = bus.data_in;
                nxt_empty = 1'b0;
            end else begin
                if (less(bus.data_in, cur_min)) nxt_min = bus.data_in;
                if (less(cur_max, bus.data_in)) nxt_max = bus.data_in;
            end
            if (cur_cnt == CNT_MAX) nxt_sat = 1'b1;
            else                    nxt_cnt = cur_cnt + 1'b1;
        end
    end

    // An empty window reports zeros regardless of stale tracker contents.
    assign res_min = nxt_empty ? '0 : nxt_min;
    assign res_max = nxt_empty ? '0 : nxt_max;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cur_min   <= '0;
            cur_max   <= '0;
            cur_cnt   <= '0;
            cur_sat   <= 1'b0;
            cur_empty <= 1'b0;
            min_q     <= '0;
            max_q     <= '0;
            range_q   <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (proto_err) begin
                state     <= S_ERROR;
                cur_min   <= '0;
                cur_max   <= '0;
                cur_cnt   <= '0;
                cur_sat   <= 1'b0;
                cur_empty <= 1'b0;
            end else if (start) begin
                state     <= S_ACTIVE;
                cur_min   <= bus.data_valid ? bus.data_in : '0;
                cur_max   <= bus.data_valid ? bus.data_in : '0;
                cur_cnt   <= bus.data_valid ? CNT_WIDTH'(1) : '0;
                cur_sat   <= 1'b0;
                cur_empty <= !bus.data_valid;
            end else if (active) begin
                cur_min   <= nxt_min;
                cur_max   <= nxt_max;
                cur_cnt   <= nxt_cnt;
                cur_sat   <= nxt_sat;
                cur_empty <= nxt_empty;
                if (bus.finish) begin
                    state   <= S_IDLE;
                    min_q   <= res_min;
                    max_q   <= res_max;
                    // max >= min in the active ordering, so the WIDTH-bit difference is exact
                    range_q <= res_max - res_min;
                    count_q <= nxt_cnt;
                    sat_q   <= nxt_sat;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.min_val   = min_q;
    assign bus.max_val   = max_q;
    assign bus.range     = range_q;
    assign bus.count     = count_q;
    assign bus.count_sat = sat_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state == S_ACTIVE);
    assign bus.error     = (state == S_ERROR);
endmodule

// File: tb/tb_range_stats_tracker.sv
// Drives an unsigned 16-bit/4-bit-count tracker and a signed 8-bit tracker
// with one stimulus stream and checks both against a window-queue model.
module tb_range_stats_tracker;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    range_stats_if #(.WIDTH(16), .CNT_WIDTH(4)) bus0 ();
    range_stats_if #(.WIDTH(8),  .CNT_WIDTH(8)) bus1 ();

    range_stats_tracker #(.WIDTH(16), .SIGNED(0), .CNT_WIDTH(4)) u0 (
        .clock(clock), .reset(reset), .bus(bus0));
    range_stats_tracker #(.WIDTH(8), .SIGNED(1), .CNT_WIDTH(8)) u1 (
        .clock(clock), .reset(reset), .bus(bus1));

    int checks   = 0;
    int failures = 0;

    // model: accepted samples of the open window, plus expected outputs per instance
    logic [15:0] win[$];
    bit open_w, err_w, done_w;
    int e_min[2], e_max[2], e_rng[2], e_cnt[2], e_sat[2];

    function automatic int sx8(input logic [7:0] b);
        return b[7] ? int'(b) - 256 : int'(b);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        open_w = 0; err_w = 0; done_w = 0;
        for (int i = 0; i < 2; i++) begin
            e_min[i] = 0; e_max[i] = 0; e_rng[i] = 0; e_cnt[i] = 0; e_sat[i] = 0;
        end
    endtask

    task automatic model_close();
        for (int i = 0; i < 2; i++) begin
            int mn, mx, v, n, cmax, mask;
            logic [15:0] s;
            mask = (i == 0) ? 32'hFFFF : 32'hFF;
            cmax = (i == 0) ? 15 : 255;
            n = win.size();
            mn = 0; mx = 0;
            for (int k = 0; k < n; k++) begin
                s = win[k];
                v = (i == 0) ? int'(s) : sx8(s[7:0]);
                if (k == 0 || v < mn) mn = v;
                if (k == 0 || v > mx) mx = v;
            end
            e_min[i] = mn & mask;
            e_max[i] = mx & mask;
            e_rng[i] = (mx - mn) & mask;
            e_cnt[i] = (n > cmax) ? cmax : n;
            e_sat[i] = (n > cmax) ? 1 : 0;
        end
    endtask

    task automatic model_step(input logic [15:0] d, input bit v, input bit g, input bit f);
        done_w = 0;
        if ((g && f) || (f && !open_w) || (g && open_w)) begin
            open_w = 0; err_w = 1; win.delete();
        end else if (g) begin
            open_w = 1; err_w = 0; win.delete();
            if (v) win.push_back(d);
        end else if (open_w) begin
            if (v) win.push_back(d);
            if (f) begin
                model_close();
                done_w = 1; open_w = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("u0.min_val",   int'(bus0.min_val),   e_min[0]);
        chk("u0.max_val",   int'(bus0.max_val),   e_max[0]);
        chk("u0.range",     int'(bus0.range),     e_rng[0]);
        chk("u0.count",     int'(bus0.count),     e_cnt[0]);
        chk("u0.count_sat", int'(bus0.count_sat), e_sat[0]);
        chk("u0.done",      int'(bus0.done),      int'(done_w));
        chk("u0.busy",      int'(bus0.busy),      int'(open_w));
        chk("u0.error",     int'(bus0.error),     int'(err_w));
        chk("u1.min_val",   int'(bus1.min_val),   e_min[1]);
        chk("u1.max_val",   int'(bus1.max_val),   e_max[1]);
        chk("u1.range",     int'(bus1.range),     e_rng[1]);
        chk("u1.count",     int'(bus1.count),     e_cnt[1]);
        chk("u1.count_sat", int'(bus1.count_sat), e_sat[1]);
        chk("u1.done",      int'(bus1.done),      int'(done_w));
        chk("u1.busy",      int'(bus1.busy),      int'(open_w));
        chk("u1.error",     int'(bus1.error),     int'(err_w));
    endtask

    task automatic cyc(input logic [15:0] d, input bit v, input bit g, input bit f);
        bus0.data_in = d;      bus1.data_in = d[7:0];
        bus0.data_valid = v;   bus1.data_valid = v;
        bus0.go = g;           bus1.go = g;
        bus0.finish = f;       bus1.finish = f;
        @(posedge clock);
        #1;
        model_step(d, v, g, f);
        check_all();
    endtask

    initial begin
        model_reset();
        bus0.data_in = '0; bus0.data_valid = 0; bus0.go = 0; bus0.finish = 0;
        bus1.data_in = '0; bus1.data_valid = 0; bus1.go = 0; bus1.finish = 0;
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;
        cyc(0, 0, 0, 0);

        // unsigned window
        cyc(16'h0010, 1, 1, 0);
        cyc(16'h0005, 1, 0, 0);
        cyc(16'h0100, 1, 0, 0);
        cyc(16'h0080, 1, 0, 0);
        cyc(16'h0003, 1, 0, 1);
        chk("t1.min", int'(bus0.min_val), 'h0003);
        chk("t1.max", int'(bus0.max_val), 'h0100);
        chk("t1.range", int'(bus0.range), 'h00FD);
        chk("t1.count", int'(bus0.count), 5);
        chk("t1.done", int'(bus0.done), 1);
        chk("t1.busy", int'(bus0.busy), 0);
        cyc(0, 0, 0, 0);
        chk("t1.done_low", int'(bus0.done), 0);

        // signed window on the 8-bit instance
        cyc(16'h00F0, 1, 1, 0);
        cyc(16'h0020, 1, 0, 0);
        cyc(16'h007F, 0, 0, 0);
        cyc(16'h0000, 1, 0, 1);
        chk("t2.min", int'(bus1.min_val), 'hF0);
        chk("t2.max", int'(bus1.max_val), 'h20);
        chk("t2.range", int'(bus1.range), 'h30);
        chk("t2.count", int'(bus1.count), 3);
        chk("t2.model_min", e_min[1], 'hF0);
        cyc(0, 0, 0, 0);

        // protocol errors
        cyc(16'h1234, 1, 1, 1);
        chk("t3.err_gofin", int'(bus0.error), 1);
        chk("t3.hold_max", int'(bus1.max_val), 'h20);
        cyc(0, 0, 0, 1);
        chk("t3.err_sticky", int'(bus0.error), 1);
        cyc(16'h0042, 1, 1, 0);
        chk("t3.err_clear", int'(bus0.error), 0);
        chk("t3.busy", int'(bus0.busy), 1);
        cyc(16'h0043, 1, 0, 0);
        cyc(16'h0044, 1, 1, 0);
        chk("t3.err_abort", int'(bus0.error), 1);
        chk("t3.busy_abort", int'(bus0.busy), 0);
        chk("t3.no_done", int'(bus0.done), 0);
        cyc(0, 0, 0, 0);

        // saturation: go plus 19 samples
        cyc(16'h0100, 1, 1, 0);
        for (int k = 0; k < 19; k++) cyc(16'(k * 7 + 3), 1, 0, 0);
        cyc(0, 0, 0, 1);
        chk("t4.count", int'(bus0.count), 15);
        chk("t4.sat", int'(bus0.count_sat), 1);
        chk("t4.count_u1", int'(bus1.count), 20);
        cyc(16'h0009, 1, 1, 0);
        cyc(16'h0002, 1, 0, 0);
        cyc(16'h0007, 1, 0, 1);
        chk("t4.count2", int'(bus0.count), 3);
        chk("t4.sat2", int'(bus0.count_sat), 0);
        chk("t4.min2", int'(bus0.min_val), 2);

        // empty window
        cyc(16'h5555, 0, 1, 0);
        cyc(16'h6666, 0, 0, 1);
        chk("t5.min", int'(bus0.min_val), 0);
        chk("t5.max", int'(bus0.max_val), 0);
        chk("t5.count", int'(bus0.count), 0);
        chk("t5.done", int'(bus0.done), 1);
        cyc(0, 0, 0, 0);

        // reset mid-window after results are nonzero
        cyc(16'h0011, 1, 1, 0);
        cyc(16'h0003, 1, 0, 1);
        cyc(16'h0020, 1, 1, 0);
        for (int k = 0; k < 3; k++) cyc(16'(k + 40), 1, 0, 0);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t6.busy", int'(bus0.busy), 0);
        chk("t6.max", int'(bus0.max_val), 0);
        #1;
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        chk("t6.no_done", int'(bus0.done), 0);
        cyc(16'h0077, 1, 1, 0);
        cyc(16'h0070, 1, 0, 1);
        chk("t6.restart_rng", int'(bus0.range), 7);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] d;
            bit v, g, f;
            d = 16'($urandom);
            v = ($urandom_range(0, 9) < 7);
            g = ($urandom_range(0, 19) == 0);
            f = ($urandom_range(0, 19) == 0);
            cyc(d, v, g, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/range_stats_tracker.md
Name: range_stats_tracker

Overview:
- Streaming min/max/range tracker over a go…finish sample window.
- Adds per-sample valid qualification, signed/unsigned operands, a saturating sample counter, registered results with a done strobe, and a sticky protocol-error state machine.
- Sits on a sensor/data stream and feeds range results to downstream control or status logic.

Parameters:
WIDTH, 16, data sample width in bits (>=2)
SIGNED, 0, 1 = samples compared as two's complement, 0 = unsigned
CNT_WIDTH, 8, width of the sample counter

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
data_in  input  WIDTH  sample value
data_valid  input  1  data_in holds a sample this cycle
go  input  1  start a new window
finish  input  1  close the current window
min_val  output  WIDTH  registered minimum of last completed window
max_val  output  WIDTH  registered maximum of last completed window
range  output  WIDTH  registered max_val - min_val, unsigned magnitude
count  output  CNT_WIDTH  samples in last completed window, saturating
count_sat  output  1  count saturated during last window
done  output  1  one-cycle pulse when results update
busy  output  1  window open (state ACTIVE)
error  output  1  protocol error, sticky in state ERROR

Behaviour:
- Reset: state IDLE; min_val, max_val, range, count = 0; count_sat, done, busy, error = 0; internal trackers = 0.
- States: IDLE, ACTIVE, ERROR. busy = (state==ACTIVE); error = (state==ERROR); both are decoded from registered state.
- Sample accept: a cycle where data_valid=1 and either (state==ACTIVE) or (valid start this cycle).
- Valid start: go=1, finish=0, state in {IDLE, ERROR} -> ACTIVE next cycle.
  - Trackers load: cur_min = cur_max = data_in, cur_cnt = 1 if data_valid, else cur_cnt = 0 with trackers marked empty.
  - Clears count_sat tracking.
- ACTIVE, accepted sample:
  - First sample after empty: load cur_min and cur_max.
  - Otherwise cur_min takes data_in if data_in < cur_min; cur_max takes data_in if data_in > cur_max.
  - Comparisons are signed when SIGNED=1.
  - cur_cnt increments and saturates at 2^CNT_WIDTH-1; the saturation sticky is set on an attempted increment past max.
- ACTIVE, finish=1, go=0 (close):
  - A sample present on this cycle is included; the results reflect it.
  - Next edge: min_val, max_val, count, count_sat load the final tracker values.
  - range = max - min, computed on WIDTH+1 bits and truncated to WIDTH; it is exact for both modes because max >= min.
  - done=1 for exactly one cycle; state -> IDLE.
  - A window with zero accepted samples closes with min_val = max_val = range = 0, count = 0, done=1.
- Errors (-> ERROR next edge; result outputs hold previous values; done=0):
  - go && finish in any state.
  - finish in IDLE or ERROR without go.
  - go while ACTIVE; the window is aborted and the tracker contents are discarded.
- ERROR is sticky until a valid start (go=1, finish=0) or reset. A valid start from ERROR behaves exactly as from IDLE, and error drops the next cycle.
- Result registers change only on close or reset. Outputs are stable between done pulses.
- Latency: results visible and done high one cycle after the finish cycle.
- Reset asserted mid-window: immediate return to the reset values; no done pulse.

Test Plan:
- Unsigned, WIDTH=16: go with data 0x0010, then samples 0x0005, 0x0100, 0x0080, then finish with 0x0003 -> next cycle min_val=0x0003, max_val=0x0100, range=0x00FD, count=5, done=1 for 1 cycle, busy=0.
- SIGNED=1, WIDTH=8: go with 0xF0 (-16), then 0x20 (+32), data_valid=0 on 0x7F, finish with 0x00 -> min_val=0xF0, max_val=0x20, range=0x30, count=3.
- Protocol errors: go&&finish in IDLE -> error=1 next cycle, results unchanged; finish alone -> error stays 1; valid go -> error=0, busy=1; go during ACTIVE -> error=1, busy=0, no done.
- Saturation, CNT_WIDTH=4: go plus 19 valid samples, then finish -> count=15, count_sat=1; next window of 3 samples -> count=3, count_sat=0.
- Empty window: go with data_valid=0, finish with data_valid=0 -> min_val=max_val=range=0, count=0, done=1.
- Async reset mid-window after 4 samples -> all outputs 0 immediately, state IDLE, no done pulse; a new go works normally.
